// File: rtl/pipeline_mem_stage_pkg.sv
// pipeline_mem_stage_pkg: shared DMEM size codes, unsigned-load bit, MEM FSM states and WB result-source codes
// Used by pipeline_mem_stage and dmem_lane_align; misaligned() flags half/word accesses off their natural boundary.
package pipeline_mem_stage_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int UNSIGNED_BIT = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT = 2'd1;
  localparam logic [1:0] ST_WAIT_RVALID = 2'd2;
  localparam logic [1:0] RESULT_SRC_ALU = 2'd0;
  localparam logic [1:0] RESULT_SRC_MEM = 2'd1;
  localparam logic [1:0] RESULT_SRC_IMM = 2'd2;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'd3;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? lo[0] : |lo;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data-memory bus
// Ports: size/is_unsigned/lo (access shape and byte offset), store_data/rdata in;
// be (byte enables), wdata (lane-replicated store data), load_data (extracted, extended load) out.
module dmem_lane_align
  import pipeline_mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        sx;
  always_comb begin
    lb = rdata[8*lo +: 8];
    lh = rdata[16*lo[1] +: 16];
    sx = ~is_unsigned;
    be = size == SIZE_BYTE ? 4'b0001 << lo : size == SIZE_HALF ? 4'b0011 << {lo[1], 1'b0} : 4'hF;
    wdata = size == SIZE_BYTE ? {4{store_data[7:0]}} : size == SIZE_HALF ? {2{store_data[15:0]}} : store_data;
    load_data = size == SIZE_BYTE ? {{24{sx & lb[7]}}, lb}
              : size == SIZE_HALF ? {{16{sx & lh[15]}}, lh} : rdata;
  end
endmodule

// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: MEM stage; drives the req/gnt/rvalid data-memory bus, stalls upstream while busy, registers the WB bundle
// Inputs *_e_i: EXE-registered instruction (alu_result is the byte address); dmem_gnt_i/rvalid_i/rdata_i: bus responses.
// Outputs: stall_m_o (combinational), dmem_* request fields, *_m_o registered WB bundle.
// Option DMEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag misaligned_m_o; otherwise low address bits are cleared.
module pipeline_mem_stage
  import pipeline_mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_e_i,
  input  logic [31:0]           alu_result_e_i,
  input  logic [31:0]           store_data_e_i,
  input  logic                  mem_read_e_i,
  input  logic                  mem_write_e_i,
  input  logic [2:0]            dmem_type_e_i,
  input  logic [31:0]           extended_imm_e_i,
  input  logic [31:0]           pc_plus4_e_i,
  input  logic                  reg_write_en_e_i,
  input  logic [4:0]            rd_idx_e_i,
  input  logic [1:0]            result_src_e_i,
  input  logic                  instr_illegal_e_i,
  output logic                  stall_m_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  valid_m_o,
  output logic [31:0]           alu_result_m_o,
  output logic [31:0]           read_data_m_o,
  output logic [31:0]           extended_imm_m_o,
  output logic [31:0]           pc_plus4_m_o,
  output logic                  reg_write_en_m_o,
  output logic [4:0]            rd_idx_m_o,
  output logic [1:0]            result_src_m_o,
  output logic                  instr_illegal_m_o,
  output logic                  misaligned_m_o
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]  size, lo, state, state_n;
  logic        mem_op, is_load, trap, access, mem_done, wb_valid;
  logic [31:0] load_data;
  assign addr = alu_result_e_i[ADDR_WIDTH-1:0];
  assign size = dmem_type_e_i[1:0];
  assign mem_op = valid_e_i & (mem_read_e_i | mem_write_e_i);
  assign is_load = mem_read_e_i;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = mem_op & misaligned(size, addr[1:0]);
  assign lo = addr[1:0];
`else
  assign trap = 1'b0;
  assign lo = size == SIZE_BYTE ? addr[1:0] : size == SIZE_HALF ? {addr[1], 1'b0} : 2'b00;
`endif
  assign access = mem_op & ~trap;
  // request fields come straight from the EXE registers, which the stall keeps frozen until completion
  assign dmem_req_o = access & (state != ST_WAIT_RVALID);
  assign dmem_we_o = dmem_req_o & ~is_load;
  assign dmem_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_done = (dmem_req_o & dmem_gnt_i & ~is_load) | (state == ST_WAIT_RVALID & dmem_rvalid_i);
  assign stall_m_o = access & ~mem_done;
  assign wb_valid = valid_e_i & ~stall_m_o;
  dmem_lane_align u_align (
    .size        (size),
    .is_unsigned (dmem_type_e_i[UNSIGNED_BIT]),
    .lo          (lo),
    .store_data  (store_data_e_i),
    .rdata       (dmem_rdata_i),
    .be          (dmem_be_o),
    .wdata       (dmem_wdata_o),
    .load_data   (load_data)
  );
  always_comb
    state_n = state == ST_WAIT_RVALID ? (dmem_rvalid_i ? ST_IDLE : ST_WAIT_RVALID)
            : !access ? ST_IDLE
            : !dmem_gnt_i ? ST_WAIT_GNT
            : is_load ? ST_WAIT_RVALID : ST_IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      valid_m_o <= 1'b0;
      alu_result_m_o <= '0;
      read_data_m_o <= '0;
      extended_imm_m_o <= '0;
      pc_plus4_m_o <= '0;
      reg_write_en_m_o <= 1'b0;
      rd_idx_m_o <= '0;
      result_src_m_o <= '0;
      instr_illegal_m_o <= 1'b0;
      misaligned_m_o <= 1'b0;
    end else begin
      state <= state_n;
      valid_m_o <= wb_valid;
      alu_result_m_o <= alu_result_e_i;
      read_data_m_o <= access & is_load ? load_data : '0;
      extended_imm_m_o <= extended_imm_e_i;
      pc_plus4_m_o <= pc_plus4_e_i;
      reg_write_en_m_o <= wb_valid & reg_write_en_e_i & ~trap;
      rd_idx_m_o <= rd_idx_e_i;
      result_src_m_o <= result_src_e_i;
      instr_illegal_m_o <= instr_illegal_e_i;
      misaligned_m_o <= wb_valid & trap;
    end
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// tb_pipeline_mem_stage: directed MEM-stage vectors with a queue scoreboard checking the WB bundle
module tb_pipeline_mem_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic valid_e_i = 0, mem_read_e_i = 0, mem_write_e_i = 0, reg_write_en_e_i = 0, instr_illegal_e_i = 0;
  logic [31:0] alu_result_e_i = 0, store_data_e_i = 0, extended_imm_e_i = 0, pc_plus4_e_i = 0;
  logic [2:0] dmem_type_e_i = 0;
  logic [4:0] rd_idx_e_i = 0;
  logic [1:0] result_src_e_i = 0;
  logic dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic [31:0] dmem_rdata_i = 0;
  logic stall_m_o, dmem_req_o, dmem_we_o, valid_m_o, reg_write_en_m_o, instr_illegal_m_o, misaligned_m_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, alu_result_m_o, read_data_m_o, extended_imm_m_o, pc_plus4_m_o;
  logic [3:0] dmem_be_o;
  logic [4:0] rd_idx_m_o;
  logic [1:0] result_src_m_o;
  int total = 0, bad = 0;
  typedef struct {
    string       name;
    logic [31:0] alu, rdat;
    logic [4:0]  rd;
    logic        we, mis;
  } exp_t;
  exp_t q[$];
  exp_t e;

  pipeline_mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_e_i(valid_e_i), .alu_result_e_i(alu_result_e_i),
    .store_data_e_i(store_data_e_i), .mem_read_e_i(mem_read_e_i), .mem_write_e_i(mem_write_e_i),
    .dmem_type_e_i(dmem_type_e_i), .extended_imm_e_i(extended_imm_e_i), .pc_plus4_e_i(pc_plus4_e_i),
    .reg_write_en_e_i(reg_write_en_e_i), .rd_idx_e_i(rd_idx_e_i), .result_src_e_i(result_src_e_i),
    .instr_illegal_e_i(instr_illegal_e_i), .stall_m_o(stall_m_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_m_o(valid_m_o), .alu_result_m_o(alu_result_m_o), .read_data_m_o(read_data_m_o),
    .extended_imm_m_o(extended_imm_m_o), .pc_plus4_m_o(pc_plus4_m_o), .reg_write_en_m_o(reg_write_en_m_o),
    .rd_idx_m_o(rd_idx_m_o), .result_src_m_o(result_src_m_o), .instr_illegal_m_o(instr_illegal_m_o),
    .misaligned_m_o(misaligned_m_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && valid_m_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got valid_m_o=1 want no pending result");
      end else begin
        e = q.pop_front();
        chk($sformatf("%s alu_result_m", e.name), alu_result_m_o, e.alu);
        chk($sformatf("%s read_data_m", e.name), read_data_m_o, e.rdat);
        chk($sformatf("%s rd_idx_m", e.name), {27'd0, rd_idx_m_o}, {27'd0, e.rd});
        chk($sformatf("%s reg_write_en_m", e.name), {31'd0, reg_write_en_m_o}, {31'd0, e.we});
        chk($sformatf("%s misaligned_m", e.name), {31'd0, misaligned_m_o}, {31'd0, e.mis});
      end
    end

  // Entered and left at posedge+1; models a memory granting after gd waiting cycles and
  // returning rvalid rl cycles after the grant.
  task automatic run_op(input string nm, input logic v, rd_, wr_, input logic [2:0] typ,
                        input logic [31:0] addr, sdata, rdata, input int gd, rl,
                        input logic xreq, input logic [31:0] xaddr, input logic [3:0] xbe,
                        input logic [31:0] xwdata, input int xstall, input logic [4:0] rdi,
                        input logic rwe, xwe, input logic [31:0] xload, input logic xmis);
    int waited, lat, stalls, cyc;
    logic ph, fin, seen;
    if (v) q.push_back('{name: nm, alu: addr, rdat: xload, rd: rdi, we: xwe, mis: xmis});
    valid_e_i = v; mem_read_e_i = rd_; mem_write_e_i = wr_; dmem_type_e_i = typ;
    alu_result_e_i = addr; store_data_e_i = sdata; reg_write_en_e_i = rwe; rd_idx_e_i = rdi;
    extended_imm_e_i = addr ^ 32'hFFFF; pc_plus4_e_i = addr + 4; result_src_e_i = rd_ ? 2'd1 : 2'd0;
    waited = 0; lat = 0; stalls = 0; cyc = 0; ph = 0; fin = 0; seen = 0;
    while (!fin && cyc < 40) begin
      #1;
      dmem_gnt_i = !ph && dmem_req_o && waited >= gd;
      dmem_rvalid_i = ph && lat == rl;
      dmem_rdata_i = dmem_rvalid_i ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (dmem_req_o) begin
        seen = 1;
        chk($sformatf("%s dmem_addr", nm), dmem_addr_o, xaddr);
        chk($sformatf("%s dmem_be", nm), {28'd0, dmem_be_o}, {28'd0, xbe});
        chk($sformatf("%s dmem_we", nm), {31'd0, dmem_we_o}, {31'd0, wr_ & ~rd_});
        if (wr_ && !rd_) chk($sformatf("%s dmem_wdata", nm), dmem_wdata_o, xwdata);
      end
      stalls += int'(stall_m_o);
      fin = !stall_m_o;
      @(posedge clk);
      #1;
      cyc++;
      if (dmem_gnt_i) begin
        ph = 1;
        lat = 1;
      end else if (ph) lat++;
      else waited++;
      dmem_gnt_i = 0;
      dmem_rvalid_i = 0;
    end
    if (!fin) chk($sformatf("%s timeout", nm), 32'(cyc), 32'd0);
    chk($sformatf("%s stall_cycles", nm), 32'(stalls), 32'(xstall));
    chk($sformatf("%s req_seen", nm), {31'd0, seen}, {31'd0, xreq});
    valid_e_i = 0; mem_read_e_i = 0; mem_write_e_i = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset valid_m", {31'd0, valid_m_o}, 32'd0);
    chk("reset alu_result_m", alu_result_m_o, 32'd0);
    chk("reset reg_write_en_m", {31'd0, reg_write_en_m_o}, 32'd0);
    chk("reset stall", {31'd0, stall_m_o}, 32'd0);
    chk("reset req", {31'd0, dmem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    //     name   v  rd wr typ     addr          sdata          rdata          gd rl req xaddr       xbe      xwdata         st rd  rwe xwe xload          mis
    run_op("alu",  1, 0, 0, 3'b010, 32'h1234,     32'h0,         32'h0,         0, 0, 0, 32'h0,      4'h0,    32'h0,         0, 5,  1, 1, 32'h0,         0);
    run_op("sb",   1, 0, 1, 3'b000, 32'h103,      32'h123456AB,  32'h0,         2, 0, 1, 32'h100,    4'b1000, 32'hABABABAB,  2, 0,  0, 0, 32'h0,         0);
    run_op("lb",   1, 1, 0, 3'b000, 32'h102,      32'h0,         32'h00800000,  0, 3, 1, 32'h100,    4'b0100, 32'h0,         3, 7,  1, 1, 32'hFFFFFF80,  0);
    run_op("lbu",  1, 1, 0, 3'b100, 32'h102,      32'h0,         32'h00800000,  0, 3, 1, 32'h100,    4'b0100, 32'h0,         3, 7,  1, 1, 32'h00000080,  0);
    run_op("lh",   1, 1, 0, 3'b001, 32'h106,      32'h0,         32'h80010000,  1, 1, 1, 32'h104,    4'b1100, 32'h0,         2, 8,  1, 1, 32'hFFFF8001,  0);
    run_op("lw",   1, 1, 0, 3'b010, 32'h108,      32'h0,         32'hDEADBEEF,  0, 1, 1, 32'h108,    4'hF,    32'h0,         1, 9,  1, 1, 32'hDEADBEEF,  0);
    run_op("lhu",  1, 1, 0, 3'b101, 32'h102,      32'h0,         32'hFFFE1234,  0, 2, 1, 32'h100,    4'b1100, 32'h0,         2, 10, 1, 1, 32'h0000FFFE,  0);
    run_op("sh",   1, 0, 1, 3'b001, 32'h106,      32'h5555BEEF,  32'h0,         0, 0, 1, 32'h104,    4'b1100, 32'hBEEFBEEF,  0, 0,  0, 0, 32'h0,         0);
    run_op("sw",   1, 0, 1, 3'b010, 32'h10C,      32'h01020304,  32'h0,         1, 0, 1, 32'h10C,    4'hF,    32'h01020304,  1, 0,  0, 0, 32'h0,         0);
`ifdef DMEM_MISALIGN_TRAP_EN
    run_op("lw_mis", 1, 1, 0, 3'b010, 32'h102,    32'h0,         32'hCAFEF00D,  0, 1, 0, 32'h0,      4'h0,    32'h0,         0, 11, 1, 0, 32'h0,         1);
`else
    run_op("lw_mis", 1, 1, 0, 3'b010, 32'h102,    32'h0,         32'hCAFEF00D,  0, 1, 1, 32'h100,    4'hF,    32'h0,         1, 11, 1, 1, 32'hCAFEF00D,  0);
`endif
    run_op("rdwr", 1, 1, 1, 3'b010, 32'h110,      32'hFFFFFFFF,  32'h11223344,  0, 1, 1, 32'h110,    4'hF,    32'h0,         1, 12, 1, 1, 32'h11223344,  0);
    run_op("nov",  0, 1, 0, 3'b010, 32'h114,      32'h0,         32'h0,         0, 1, 0, 32'h0,      4'h0,    32'h0,         0, 13, 1, 0, 32'h0,         0);
    // reset while a load waits for rvalid
    alu_result_e_i = 32'h120; mem_read_e_i = 1; mem_write_e_i = 0; dmem_type_e_i = 3'b010;
    valid_e_i = 1; rd_idx_e_i = 5'd9; reg_write_en_e_i = 1;
    #1 dmem_gnt_i = dmem_req_o;
    chk("rst_seq req", {31'd0, dmem_req_o}, 32'd1);
    @(posedge clk);
    #1 dmem_gnt_i = 0;
    @(negedge clk);
    chk("rst_seq waiting stall", {31'd0, stall_m_o}, 32'd1);
    @(posedge clk);
    #1 reset = 1; valid_e_i = 0; mem_read_e_i = 0;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_seq valid_m", {31'd0, valid_m_o}, 32'd0);
    chk("rst_seq read_data_m", read_data_m_o, 32'd0);
    chk("rst_seq alu_result_m", alu_result_m_o, 32'd0);
    chk("rst_seq stall", {31'd0, stall_m_o}, 32'd0);
    @(posedge clk);
    #1 dmem_rvalid_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_rvalid stall", {31'd0, stall_m_o}, 32'd0);
    chk("late_rvalid req", {31'd0, dmem_req_o}, 32'd0);
    @(posedge clk);
    #1 dmem_rvalid_i = 0;
    @(negedge clk);
    chk("late_rvalid valid_m", {31'd0, valid_m_o}, 32'd0);
    chk("late_rvalid read_data_m", read_data_m_o, 32'd0);
    @(posedge clk);
    #1;
    run_op("lw_post", 1, 1, 0, 3'b010, 32'h124,   32'h0,         32'h0BADCAFE,  1, 2, 1, 32'h124,    4'hF,    32'h0,         3, 14, 1, 1, 32'h0BADCAFE,  0);
    repeat (3) @(posedge clk);
    #1 chk("drain pending", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_mem_stage.md
Name: pipeline_mem_stage

Overview:
- MEM stage of the 5-stage pipeline, sitting between EXE and WB; it consumes EXE's registered outputs.
- Uses EXE's ALU result as the data-memory address and runs loads/stores over a req/gnt/rvalid data-memory bus.
- Aligns, byte-enables and sign/zero-extends data, and stalls upstream while an access is outstanding.
- Registers the WB-stage bundle (ALU result, load data, imm, pc+4, rd, result_src, illegal flag).

Parameters:
- ADDR_WIDTH, 32, data-memory byte-address width; the address is the low ADDR_WIDTH bits of alu_result_e_i.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_e_i  in  1  EXE stage holds a valid instruction
- alu_result_e_i  in  32  ALU result / memory byte address
- store_data_e_i  in  32  rs2 value for stores
- mem_read_e_i  in  1  instruction is a load
- mem_write_e_i  in  1  instruction is a store
- dmem_type_e_i  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load
- extended_imm_e_i  in  32  passthrough
- pc_plus4_e_i  in  32  passthrough
- reg_write_en_e_i  in  1  passthrough
- rd_idx_e_i  in  5  passthrough
- result_src_e_i  in  2  passthrough
- instr_illegal_e_i  in  1  passthrough
- stall_m_o  out  1  freeze IF/ID/EXE this cycle
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load data
- valid_m_o, alu_result_m_o(32), read_data_m_o(32), extended_imm_m_o(32), pc_plus4_m_o(32), reg_write_en_m_o, rd_idx_m_o(5), result_src_m_o(2), instr_illegal_m_o, misaligned_m_o  out  registered WB bundle

Behaviour:
- Reset: all registered outputs 0; FSM to IDLE; any outstanding access abandoned. An rvalid arriving in IDLE is ignored.
- FSM states and transitions:
  - IDLE: if valid_e_i and (mem_read or mem_write) and aligned, assert dmem_req_o combinationally from the inputs.
    - gnt same cycle: a store completes; a load goes to WAIT_RVALID.
    - no gnt: go to WAIT_GNT.
  - WAIT_GNT: req and all bus fields held stable (inputs are frozen by the stall) until gnt, then transition as in IDLE.
  - WAIT_RVALID: req = 0; on rvalid, the load completes and the FSM returns to IDLE.
  - rvalid is legal no earlier than the cycle after gnt.
- Latency:
  - Non-memory instructions: 1 cycle, registered at the next edge (same as the EXE→MEM boundary).
  - Store: completes in its gnt cycle.
  - Load: completes in its rvalid cycle.
  - The WB bundle is registered on the completion edge.
- stall_m_o = valid memory op AND NOT completing this cycle; it is combinational.
- While stalled, the WB register loads a bubble: valid_m_o = 0, reg_write_en_m_o = 0, other fields don't-care.
- Byte enables and store data:
  - Byte: be = 1<<addr[1:0]; wdata = {4{byte}}.
  - Half: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{half}}.
  - Word: be = 4'hF.
- Load extract:
  - Byte: rdata[8*addr[1:0]+:8].
  - Half: rdata[16*addr[1]+:16].
  - Result sign-extended unless dmem_type[2] = 1.
- read_data_m_o = 0 for non-loads.
- Misalignment check: half with addr[0] = 1, or word with addr[1:0] != 0.
- If valid_e_i = 0, the stage issues a bubble and never requests, whatever mem_read/mem_write are.
- mem_read and mem_write both set is treated as a load.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no request and completes in 1 cycle with misaligned_m_o = 1 and reg_write_en_m_o forced to 0.
- Undefined: misaligned_m_o is tied to 0; the offending low address bits are cleared (half: addr[0]; word: addr[1:0]) and the access proceeds normally.

Decomposition:
- Shared definitions header: DMEM size codes (BYTE/HALF/WORD), unsigned bit index, FSM state encodings, RESULT_SRC codes.
- One natural sub-module: dmem_lane_align, purely combinational; maps (size, unsigned, addr[1:0], store_data, rdata) to (be, wdata, load_data). The FSM and WB register stay in pipeline_mem_stage.

Test Plan:
- ALU-only instruction: alu_result = 0x1234, rd = 5, reg_write_en = 1 → next edge alu_result_m_o = 0x1234, rd_idx_m_o = 5, valid_m_o = 1; req never asserted; stall_m_o = 0.
- SB at addr 0x103, data 0xAB, gnt held low for 2 cycles:
  - stall_m_o high for 2 cycles.
  - dmem_addr_o = 0x100, be = 4'b1000, wdata = 0xABABABAB, all stable while waiting.
  - Completes on the gnt cycle.
- LB at 0x102 (signed) with gnt immediate, rvalid 3 cycles later, rdata = 0x00800000:
  - read_data_m_o = 0xFFFFFF80.
  - Same access as LBU gives 0x00000080.
  - stall_m_o high until the rvalid cycle.
- LH at 0x106 with rdata = 0x8001_0000 → read_data_m_o = 0xFFFF8001. LW at 0x108 → rdata passed through unmodified.
- LW at 0x102:
  - DMEM_MISALIGN_TRAP_EN defined: no req, misaligned_m_o = 1, reg_write_en_m_o = 0 after 1 cycle.
  - Undefined: req to 0x100 proceeds.
- Reset asserted in WAIT_RVALID: outputs 0, FSM to IDLE; a late rvalid has no effect; the next load proceeds normally.
